// File: rtl/coin_dispenser_if.sv
// Vending coin-pulse interface: change request handshake, hopper status and coin eject pulses.
// The dispenser sits on the slave side; the vending controller drives the master side.
interface coin_dispenser_if #(
  parameter int unsigned AMT_W = 4
);
  logic             io_req_valid;
  logic [AMT_W-1:0] io_req_amount;
  logic             io_req_ready;
  logic             io_dime_empty;
  logic             io_nickel_empty;
  logic             io_nickel;
  logic             io_dime;
  logic             io_stall;
  logic             io_done;

  modport master (
    output io_req_valid, io_req_amount, io_dime_empty, io_nickel_empty,
    input  io_req_ready, io_nickel, io_dime, io_stall, io_done
  );

  modport slave (
    input  io_req_valid, io_req_amount, io_dime_empty, io_nickel_empty,
    output io_req_ready, io_nickel, io_dime, io_stall, io_done
  );
endinterface

// File: rtl/coin_dispenser.sv
// Change dispenser: greedy dime-first coin pulses with a programmable gap between coins,
// falling back to nickels when the dime hopper is empty and stalling when nothing fits.
module coin_dispenser #(
  parameter int unsigned AMT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input logic              clk,
  input logic              reset,
  coin_dispenser_if.slave  bus
);
  localparam int unsigned GapW = (GAP == 0) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [AMT_W-1:0] r_remaining, w_remaining_d, w_left;
  logic [GapW-1:0]  r_gap, w_gap_d;
  logic             w_ready, w_nickel, w_dime, w_stall, w_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_gap       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
      r_gap       <= w_gap_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_gap_d       = r_gap;
    w_left        = r_remaining;
    w_ready       = 1'b0;
    w_nickel      = 1'b0;
    w_dime        = 1'b0;
    w_stall       = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ready = 1'b1;
        if (bus.io_req_valid) begin
          if (bus.io_req_amount != '0) begin
            w_remaining_d = bus.io_req_amount;
            w_state_d     = StIssue;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StIssue: begin
        // Dime only when at least two nickels remain, so remaining cannot underflow.
        if (r_remaining >= AMT_W'(2) && !bus.io_dime_empty) begin
          w_dime = 1'b1;
          w_left = r_remaining - AMT_W'(2);
        end else if (!bus.io_nickel_empty) begin
          w_nickel = 1'b1;
          w_left   = r_remaining - AMT_W'(1);
        end else begin
          w_stall = 1'b1;
        end
        if (w_dime || w_nickel) begin
          w_remaining_d = w_left;
          if (w_left == '0) begin
            w_state_d = StDone;
          end else if (GAP != 0) begin
            w_gap_d   = GapW'(GAP);
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        w_gap_d = r_gap - GapW'(1);
        if (r_gap <= GapW'(1)) begin
          w_state_d = StIssue;
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.io_req_ready = w_ready;
  assign bus.io_nickel    = w_nickel;
  assign bus.io_dime      = w_dime;
  assign bus.io_stall     = w_stall;
  assign bus.io_done      = w_done;
endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser: one GAP=1 and one GAP=0 instance, outputs checked
// mid-cycle as {ready, nickel, dime, stall, done} against hand-computed vectors.
module tb_coin_dispenser;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  coin_dispenser_if #(.AMT_W(4)) bus1 ();
  coin_dispenser_if #(.AMT_W(4)) bus0 ();

  coin_dispenser #(.AMT_W(4), .GAP(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  coin_dispenser #(.AMT_W(4), .GAP(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] N  = 5'b01000;
  localparam logic [4:0] Dm = 5'b00100;
  localparam logic [4:0] S  = 5'b00010;
  localparam logic [4:0] Dn = 5'b00001;
  localparam logic [4:0] Z  = 5'b00000;

  function automatic logic [4:0] obs1();
    return {bus1.io_req_ready, bus1.io_nickel, bus1.io_dime, bus1.io_stall, bus1.io_done};
  endfunction

  function automatic logic [4:0] obs0();
    return {bus0.io_req_ready, bus0.io_nickel, bus0.io_dime, bus0.io_stall, bus0.io_done};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check the current cycle mid-period, then advance one clock.
  task automatic cyc1(input string tag, input logic [4:0] exp);
    #2;
    chk(tag, obs1(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc0(input string tag, input logic [4:0] exp);
    #2;
    chk(tag, obs0(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus1.io_req_valid = 1'b0; bus1.io_req_amount = '0;
    bus1.io_dime_empty = 1'b0; bus1.io_nickel_empty = 1'b0;
    bus0.io_req_valid = 1'b0; bus0.io_req_amount = '0;
    bus0.io_dime_empty = 1'b0; bus0.io_nickel_empty = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    #2;
    chk("reset_dut1", obs1(), R);
    chk("reset_dut0", obs0(), R);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Amount 5, GAP=1: dime, gap, dime, gap, nickel, done.
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd5;
    cyc1("a5_c0", R);
    bus1.io_req_valid = 1'b0;
    cyc1("a5_c1", Dm);
    cyc1("a5_c2", Z);
    cyc1("a5_c3", Dm);
    cyc1("a5_c4", Z);
    cyc1("a5_c5", N);
    cyc1("a5_c6", Dn);
    cyc1("a5_c7", R);

    // Amount 0: straight to done.
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd0;
    cyc1("a0_c0", R);
    bus1.io_req_valid = 1'b0;
    cyc1("a0_c1", Dn);
    cyc1("a0_c2", R);

    // GAP=0, dime hopper empty, amount 3: three back-to-back nickels.
    bus0.io_dime_empty = 1'b1;
    bus0.io_req_valid = 1'b1; bus0.io_req_amount = 4'd3;
    cyc0("g0_de_c0", R);
    bus0.io_req_valid = 1'b0;
    cyc0("g0_de_c1", N);
    cyc0("g0_de_c2", N);
    cyc0("g0_de_c3", N);
    cyc0("g0_de_c4", Dn);
    cyc0("g0_de_c5", R);
    bus0.io_dime_empty = 1'b0;

    // GAP=0, amount 5: dime, dime, nickel with no gaps.
    bus0.io_req_valid = 1'b1; bus0.io_req_amount = 4'd5;
    cyc0("g0_a5_c0", R);
    bus0.io_req_valid = 1'b0;
    cyc0("g0_a5_c1", Dm);
    cyc0("g0_a5_c2", Dm);
    cyc0("g0_a5_c3", N);
    cyc0("g0_a5_c4", Dn);
    cyc0("g0_a5_c5", R);

    // Amount 1 with nickel hopper empty for four cycles.
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd1;
    cyc1("stall_c0", R);
    bus1.io_req_valid = 1'b0;
    bus1.io_nickel_empty = 1'b1;
    cyc1("stall_c1", S);
    cyc1("stall_c2", S);
    cyc1("stall_c3", S);
    cyc1("stall_c4", S);
    bus1.io_nickel_empty = 1'b0;
    cyc1("stall_c5", N);
    cyc1("stall_c6", Dn);
    cyc1("stall_c7", R);

    // Amount 6, reset during the second gap cycle drops the request.
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd6;
    cyc1("rst_c0", R);
    bus1.io_req_valid = 1'b0;
    cyc1("rst_c1", Dm);
    cyc1("rst_c2", Z);
    cyc1("rst_c3", Dm);
    reset = 1'b0;
    cyc1("rst_c4", Z);
    reset = 1'b1;
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd2;
    cyc1("rst_c5", R);
    bus1.io_req_valid = 1'b0;
    cyc1("rst_c6", Dm);
    cyc1("rst_c7", Dn);
    cyc1("rst_c8", R);

    // Valid held high: one acceptance per IDLE visit.
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd2;
    cyc1("hold_c0", R);
    cyc1("hold_c1", Dm);
    cyc1("hold_c2", Dn);
    cyc1("hold_c3", R);
    cyc1("hold_c4", Dm);
    cyc1("hold_c5", Dn);
    bus1.io_req_valid = 1'b0;
    cyc1("hold_c6", R);

    // GAP=1, dime hopper empty, amount 2: nickel, gap, nickel.
    bus1.io_dime_empty = 1'b1;
    bus1.io_req_valid = 1'b1; bus1.io_req_amount = 4'd2;
    cyc1("de_c0", R);
    bus1.io_req_valid = 1'b0;
    cyc1("de_c1", N);
    cyc1("de_c2", Z);
    cyc1("de_c3", N);
    cyc1("de_c4", Dn);
    cyc1("de_c5", R);
    bus1.io_dime_empty = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
